// File: rtl/maxpool_stream_2x2.sv
//------------------------------------------------------------------------------
// Module   : maxpool_stream_2x2
// Summary  : Streaming 2x2 / stride-2 signed max-pool stage. Takes raster-order
//            convolution results and emits one pooled value per 2x2 window.
//            Only a half-width line buffer is kept, never the full map.
// Options  : define MAXPOOL_RELU_EN to clamp negative pooled results to 0.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module maxpool_stream_2x2 #(
  parameter int DATA_W = 21,
  parameter int IMG_W  = 26,
  parameter int IMG_H  = 26
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              in_ready_o,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  input  logic              out_ready_i,
  output logic              done_o,
  output logic              busy_o
);

  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int HALF  = (IMG_W / 2 > 0) ? IMG_W / 2 : 1;
  localparam int IDX_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [DATA_W-1:0] pair_q, pair_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;

  // Half-width line buffer: one horizontal max per column pair of the even row.
  logic [DATA_W-1:0] line_q [HALF];

  logic              in_ready;
  logic              in_fire;
  logic [COL_W-1:0]  col_half;
  logic [IDX_W-1:0]  buf_idx;
  logic [DATA_W-1:0] hmax;
  logic [DATA_W-1:0] buf_rd;
  logic [DATA_W-1:0] vmax;
  logic [DATA_W-1:0] result;

  // A new sample may enter only when the output slot is free or draining now.
  assign in_ready = (state_q == S_RUN) && (!out_valid_q || out_ready_i);
  assign in_fire  = in_valid_i && in_ready;
  assign col_half = col_q >> 1;
  assign buf_idx  = col_half[IDX_W-1:0];

  // Signed horizontal and vertical maxima, plus optional ReLU clamp.
  always_comb begin
    hmax   = ($signed(in_data_i) > $signed(pair_q)) ? in_data_i : pair_q;
    buf_rd = line_q[buf_idx];
    vmax   = ($signed(hmax) > $signed(buf_rd)) ? hmax : buf_rd;
`ifdef MAXPOOL_RELU_EN
    result = vmax[DATA_W-1] ? '0 : vmax;
`else
    result = vmax;
`endif
  end

  // Next-state and raster counter logic.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_RUN;
          col_d   = '0;
          row_d   = '0;
        end
      end
      S_RUN: begin
        if (in_fire) begin
          if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q == ROW_LAST) begin
              row_d   = '0;
              state_d = S_FLUSH;
            end else begin
              row_d = row_q + ROW_W'(1);
            end
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end
      S_FLUSH: begin
        if (!out_valid_q || out_ready_i) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Pair register and output slot; an odd-row/odd-col sample completes a window.
  // An odd trailing column or row lands on an even index and never completes one.
  always_comb begin
    pair_d      = pair_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (out_valid_q && out_ready_i) begin
      out_valid_d = 1'b0;
    end
    if (in_fire) begin
      if (!col_q[0]) begin
        pair_d = in_data_i;
      end else if (row_q[0]) begin
        out_valid_d = 1'b1;
        out_data_d  = result;
      end
    end
  end

  // Control and datapath registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      pair_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      pair_q      <= pair_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // Line buffer captures the even-row horizontal max; contents need no reset.
  always_ff @(posedge clk) begin
    if (in_fire && col_q[0] && !row_q[0]) begin
      line_q[buf_idx] <= hmax;
    end
  end

  assign in_ready_o  = in_ready;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign done_o      = (state_q == S_DONE);
  assign busy_o      = (state_q == S_RUN) || (state_q == S_FLUSH);

endmodule

`default_nettype wire

// File: tb/tb_maxpool_stream_2x2.sv
`default_nettype none

module tb_maxpool_stream_2x2;

  localparam int DW = 21;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic out_ready = 1'b0;
  logic [2:0] start_v = '0;

  logic [2:0] ir, ov, dn, bz;
  logic [DW-1:0] od [3];

  int sel = 0;
  logic ir_m, ov_m, dn_m, bz_m;
  logic [DW-1:0] od_m;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Instance 0: 4x4, instance 1: 5x5, instance 2: default 26x26.
  maxpool_stream_2x2 #(.DATA_W(DW), .IMG_W(4), .IMG_H(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start_i(start_v[0]), .in_valid_i(in_valid),
    .in_data_i(in_data), .in_ready_o(ir[0]), .out_valid_o(ov[0]), .out_data_o(od[0]),
    .out_ready_i(out_ready), .done_o(dn[0]), .busy_o(bz[0]));

  maxpool_stream_2x2 #(.DATA_W(DW), .IMG_W(5), .IMG_H(5)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .start_i(start_v[1]), .in_valid_i(in_valid),
    .in_data_i(in_data), .in_ready_o(ir[1]), .out_valid_o(ov[1]), .out_data_o(od[1]),
    .out_ready_i(out_ready), .done_o(dn[1]), .busy_o(bz[1]));

  maxpool_stream_2x2 u_dut26 (
    .clk(clk), .rst_n(rst_n), .start_i(start_v[2]), .in_valid_i(in_valid),
    .in_data_i(in_data), .in_ready_o(ir[2]), .out_valid_o(ov[2]), .out_data_o(od[2]),
    .out_ready_i(out_ready), .done_o(dn[2]), .busy_o(bz[2]));

  always_comb begin
    ir_m = ir[sel];
    ov_m = ov[sel];
    dn_m = dn[sel];
    bz_m = bz[sel];
    od_m = od[sel];
  end

  // mode: 0 ramp, 1 negatives, 2 random.  bp: 0 ready, 1 five stalled cycles, 2 random.
  task automatic run_map(input int w, input int h, input int mode, input int bp,
                         input bit glitch, input int abort_after, input string name);
    int pix[$];
    int expq[$];
    int n, idx, cyc, budget, got, donecnt, lowcnt, last_out, post, m, v;
    bit seen_done, prev_hold, aborted;
    logic [DW-1:0] prev_data;
    n = w * h;
    idx = 0; cyc = 0; got = 0; donecnt = 0; lowcnt = 0; last_out = -10; post = 0;
    seen_done = 0; prev_hold = 0; aborted = 0; prev_data = '0;
    budget = 20 * n + 100;
    sel = (w == 4) ? 0 : ((w == 5) ? 1 : 2);

    for (int i = 0; i < n; i++) begin
      case (mode)
        0: pix.push_back(i);
        1: pix.push_back((i == w) ? -3 : -100);
        default: pix.push_back(int'($urandom_range(0, (1 << DW) - 1)) - (1 << (DW - 1)));
      endcase
    end

    // Reference: maximum over each complete 2x2 window, raster order of windows.
    for (int r = 0; r < h / 2; r++) begin
      for (int c = 0; c < w / 2; c++) begin
        m = pix[(2 * r) * w + 2 * c];
        for (int dy = 0; dy < 2; dy++) begin
          for (int dx = 0; dx < 2; dx++) begin
            v = pix[(2 * r + dy) * w + 2 * c + dx];
            if (v > m) m = v;
          end
        end
`ifdef MAXPOOL_RELU_EN
        if (m < 0) m = 0;
`endif
        expq.push_back(m);
      end
    end

    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    start_v[sel] = 1'b1;
    @(negedge clk);
    start_v = '0;
    #1;
    checks++;
    if (bz_m !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_after_start: got %b want 1", name, bz_m);
    end

    while (cyc < budget && !(seen_done && post >= 3) && !aborted) begin
      if (abort_after > 0 && idx == abort_after) begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++;
        if (ov_m !== 1'b0) begin
          errors++;
          $display("FAIL %s out_valid_in_reset: got %b want 0", name, ov_m);
        end
        checks++;
        if (bz_m !== 1'b0) begin
          errors++;
          $display("FAIL %s busy_in_reset: got %b want 0", name, bz_m);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        aborted = 1;
      end else begin
        in_valid = (idx < n) && (mode != 2 || $urandom_range(0, 3) != 0);
        in_data = (idx < n) ? DW'(pix[idx]) : '0;
        if (bp == 0)      out_ready = 1'b1;
        else if (bp == 1) out_ready = !(got == 0 && lowcnt < 5);
        else              out_ready = ($urandom_range(0, 1) == 1);
        start_v[sel] = glitch && (idx == 3 || idx == 9);
        #1;
        if (prev_hold) begin
          checks++;
          if (ov_m !== 1'b1 || od_m !== prev_data) begin
            errors++;
            $display("FAIL %s output_hold: got v=%b d=%0d want v=1 d=%0d", name,
                     ov_m, $signed(od_m), $signed(prev_data));
          end
        end
        if (ov_m && !out_ready) begin
          checks++;
          if (ir_m !== 1'b0) begin
            errors++;
            $display("FAIL %s in_ready_under_stall: got %b want 0", name, ir_m);
          end
          lowcnt++;
        end
        prev_hold = ov_m && !out_ready;
        prev_data = od_m;
        if (in_valid && ir_m) idx++;
        if (ov_m && out_ready) begin
          checks++;
          if (expq.size() == 0) begin
            errors++;
            $display("FAIL %s extra_output: got %0d want none", name, $signed(od_m));
          end else begin
            m = expq.pop_front();
            if (od_m !== DW'(m)) begin
              errors++;
              $display("FAIL %s out_data[%0d]: got %0d want %0d", name, got, $signed(od_m), m);
            end
          end
          got++;
          last_out = cyc;
        end
        if (seen_done) post++;
        if (dn_m) begin
          donecnt++;
          if (!seen_done && (w % 2 == 0) && (h % 2 == 0)) begin
            checks++;
            if (cyc != last_out + 1) begin
              errors++;
              $display("FAIL %s done_timing: got cycle %0d want %0d", name, cyc, last_out + 1);
            end
          end
          seen_done = 1;
        end
        cyc++;
        @(negedge clk);
      end
    end
    start_v = '0;
    in_valid = 1'b0;

    if (aborted) begin
      repeat (3) @(negedge clk);
      checks++;
      if (ov_m !== 1'b0 || bz_m !== 1'b0) begin
        errors++;
        $display("FAIL %s after_abort_idle: got v=%b busy=%b want 0 0", name, ov_m, bz_m);
      end
    end else if (!seen_done) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: got no done within %0d cycles want done", name, budget);
    end else begin
      checks++;
      if (donecnt != 1) begin
        errors++;
        $display("FAIL %s done_count: got %0d want 1", name, donecnt);
      end
      checks++;
      if (expq.size() != 0 || got != (w / 2) * (h / 2)) begin
        errors++;
        $display("FAIL %s output_count: got %0d want %0d", name, got, (w / 2) * (h / 2));
      end
      checks++;
      if (idx != n) begin
        errors++;
        $display("FAIL %s inputs_accepted: got %0d want %0d", name, idx, n);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ir[i] !== 1'b0 || ov[i] !== 1'b0 || dn[i] !== 1'b0 || bz[i] !== 1'b0 || od[i] !== '0) begin
        errors++;
        $display("FAIL reset_state[%0d]: got ir=%b ov=%b dn=%b bz=%b od=%0d want all 0",
                 i, ir[i], ov[i], dn[i], bz[i], od[i]);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ramp();
    run_map(4, 4, 0, 0, 1'b0, 0, "ramp4x4");
  endtask

  task automatic test_negatives();
    run_map(4, 4, 1, 0, 1'b0, 0, "negatives4x4");
  endtask

  task automatic test_backpressure();
    run_map(4, 4, 0, 1, 1'b0, 0, "backpressure4x4");
  endtask

  task automatic test_odd_size();
    run_map(5, 5, 0, 0, 1'b0, 0, "odd5x5");
  endtask

  task automatic test_reset_mid_map();
    run_map(4, 4, 0, 0, 1'b0, 6, "abort4x4");
    run_map(4, 4, 0, 0, 1'b0, 0, "ramp_after_abort");
  endtask

  task automatic test_start_during_run();
    run_map(4, 4, 0, 0, 1'b1, 0, "start_glitch4x4");
  endtask

  task automatic test_random_default();
    run_map(26, 26, 2, 2, 1'b0, 0, "random26x26");
  endtask

  task automatic test_back_to_back();
    run_map(4, 4, 2, 2, 1'b0, 0, "b2b_a");
    run_map(4, 4, 2, 2, 1'b0, 0, "b2b_b");
    run_map(5, 5, 2, 2, 1'b0, 0, "b2b_odd");
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_negatives();
    test_backpressure();
    test_odd_size();
    test_reset_mid_map();
    test_start_during_run();
    test_random_default();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
